// File: rtl/serial_pattern_pkg.sv
// Shared state encodings and parameter defaults for the serial pattern transmitter.
// The state codes double as the LEDR[2:0] status display.
package serial_pattern_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      SHIFT = 3'b001,
      DONE  = 3'b010
   } state_e;

   localparam int WIDTH_DEF = 8;
   localparam int LEN_W_DEF = 4;
   localparam int REP_W_DEF = 4;

endpackage

// File: rtl/pattern_shift_reg.sv
// Holds the latched pattern and the down-counting bit index; wraps back to the
// top bit on a shift from bit 0 so consecutive passes run without a gap.
module pattern_shift_reg #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] length,
   output logic             bit_nxt,
   output logic             last
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] pat_q, pat_d;
   logic [IDX_W-1:0] top_q, top_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   assign last = (idx_q == '0);

   always_comb begin
      pat_d = pat_q;
      top_d = top_q;
      idx_d = idx_q;
      if (load) begin
         // length is already clamped to 1..WIDTH by the caller
         pat_d = pattern;
         top_d = IDX_W'(length - LEN_W'(1));
         idx_d = IDX_W'(length - LEN_W'(1));
      end else if (shift) begin
         idx_d = last ? top_q : idx_q - IDX_W'(1);
      end
   end

   // Bit that will be current after this edge, so the caller can register it.
   assign bit_nxt = pat_d[idx_d];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q <= '0;
         top_q <= '0;
         idx_q <= '0;
      end else begin
         pat_q <= pat_d;
         top_q <= top_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first for a
// number of passes, one bit per bit_en tick, with registered Moore outputs.
module serial_pattern_tx
   import serial_pattern_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int REP_W = REP_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] length,
   input  logic [REP_W-1:0] passes,
   input  logic             bit_en,
   output logic             out,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [8:0]       LEDR
);

   state_e           state_q, state_d;
   logic [REP_W-1:0] pass_q, pass_d;
   logic             out_q, out_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [LEN_W-1:0] len_c;
   logic             load, shift, bit_nxt, last;

   assign len_c = (length > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : length;

   pattern_shift_reg #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) u_sr (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .shift   (shift),
      .pattern (pattern),
      .length  (len_c),
      .bit_nxt (bit_nxt),
      .last    (last)
   );

   // pass_q counts the passes still to run after the current one.
   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len_c != '0 && passes != '0) begin
                  load    = 1'b1;
                  pass_d  = passes - REP_W'(1);
                  state_d = SHIFT;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SHIFT: begin
            if (bit_en) begin
               if (last && pass_q == '0) begin
                  state_d = DONE;
               end else begin
                  shift = 1'b1;
                  if (last) pass_d = pass_q - REP_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      out_d   = (state_d == SHIFT) ? bit_nxt : 1'b0;
      valid_d = (state_d == SHIFT);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pass_q  <= '0;
         out_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign LEDR  = {4'b0000, valid_q, out_q, state_q};

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: directed vector table, reset/re-start sequences,
// and a randomized run against a queue-based reference model.
module tb_serial_pattern_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] pattern = '0;
   logic [3:0] length = '0;
   logic [3:0] passes = '0;
   logic       bit_en = 1'b0;
   logic       out, valid, busy, done;
   logic [8:0] LEDR;

   int total = 0;
   int bad = 0;

   serial_pattern_tx dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .pattern (pattern),
      .length  (length),
      .passes  (passes),
      .bit_en  (bit_en),
      .out     (out),
      .valid   (valid),
      .busy    (busy),
      .done    (done),
      .LEDR    (LEDR)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  pat;
      logic [3:0]  len;
      logic [3:0]  rep;
      logic [31:0] en_mask;  // bit k = bit_en during cycle k
      logic [31:0] exp_out;  // bit k = expected out in cycle k
      logic [31:0] exp_vld;
      int          done_cyc;
      int          repulse;  // cycle to re-pulse start with junk, 0 = none
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int vi, input vec_t v);
      @(negedge clk);
      start   = 1'b1;
      pattern = v.pat;
      length  = v.len;
      passes  = v.rep;
      bit_en  = v.en_mask[0];
      for (int k = 1; k <= v.done_cyc + 1; k++) begin
         @(negedge clk);
         if (k <= v.done_cyc) begin
            chk($sformatf("v%0d c%0d out", vi, k), 16'(out), 16'(v.exp_out[k]));
            chk($sformatf("v%0d c%0d valid", vi, k), 16'(valid), 16'(v.exp_vld[k]));
            chk($sformatf("v%0d c%0d busy", vi, k), 16'(busy), 16'd1);
            chk($sformatf("v%0d c%0d done", vi, k), 16'(done), 16'(k == v.done_cyc));
         end else begin
            chk($sformatf("v%0d idle", vi), 16'({out, valid, busy, done}), 16'h0);
            chk($sformatf("v%0d idle LEDR", vi), 16'(LEDR), 16'h0);
         end
         bit_en = v.en_mask[k];
         if (k == v.repulse) begin
            start   = 1'b1;
            pattern = 8'hFF;
            length  = 4'd8;
            passes  = 4'd3;
         end else begin
            start   = 1'b0;
            pattern = 8'($urandom);
            length  = 4'($urandom);
            passes  = 4'($urandom);
         end
      end
      start = 1'b0;
   endtask

   // Reference model: a queue of bits still to send plus a coarse phase.
   int   mphase = 0;  // 0 idle, 1 sending, 2 done pulse
   logic bq[$];

   task automatic model_step(input logic s, input logic [7:0] p, input logic [3:0] l,
                             input logic [3:0] r, input logic en);
      int lc;
      case (mphase)
         0: if (s) begin
            lc = (l > 4'd8) ? 8 : int'(l);
            if (lc > 0 && r > 0) begin
               for (int pp = 0; pp < int'(r); pp++)
                  for (int i = lc - 1; i >= 0; i--) bq.push_back(p[i]);
               mphase = 1;
            end else begin
               mphase = 2;
            end
         end
         1: if (en) begin
            void'(bq.pop_front());
            if (bq.size() == 0) mphase = 2;
         end
         default: mphase = 0;
      endcase
   endtask

   task automatic run_random(input int ncyc);
      logic       e_out, e_vld;
      logic [8:0] e_led;
      mphase = 0;
      bq.delete();
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         e_vld = (mphase == 1);
         e_out = e_vld ? bq[0] : 1'b0;
         e_led = {4'b0, e_vld, e_out, 3'(mphase)};
         chk($sformatf("rnd c%0d out", c), 16'(out), 16'(e_out));
         chk($sformatf("rnd c%0d valid", c), 16'(valid), 16'(e_vld));
         chk($sformatf("rnd c%0d busy", c), 16'(busy), 16'(mphase != 0));
         chk($sformatf("rnd c%0d done", c), 16'(done), 16'(mphase == 2));
         chk($sformatf("rnd c%0d LEDR", c), 16'(LEDR), 16'(e_led));
         start   = ($urandom_range(0, 3) == 0);
         pattern = 8'($urandom);
         length  = 4'($urandom_range(0, 10));
         passes  = 4'($urandom_range(0, 3));
         bit_en  = ($urandom_range(0, 3) != 0);
         model_step(start, pattern, length, passes, bit_en);
      end
   endtask

   initial begin
      vecs[0] = '{8'h0A, 4'd4,  4'd1, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_001E, 5, 0};
      vecs[1] = '{8'h0A, 4'd4,  4'd2, 32'hFFFF_FFFF, 32'h0000_00AA, 32'h0000_01FE, 9, 0};
      vecs[2] = '{8'h0A, 4'd4,  4'd1, 32'h5555_5555, 32'h0000_0066, 32'h0000_01FE, 9, 0};
      vecs[3] = '{8'h0A, 4'd0,  4'd1, 32'hFFFF_FFFF, 32'h0,         32'h0,         1, 0};
      vecs[4] = '{8'h0A, 4'd4,  4'd0, 32'hFFFF_FFFF, 32'h0,         32'h0,         1, 0};
      vecs[5] = '{8'hC5, 4'd12, 4'd1, 32'hFFFF_FFFF, 32'h0000_0146, 32'h0000_01FE, 9, 0};
      vecs[6] = '{8'h01, 4'd1,  4'd3, 32'hFFFF_FFFF, 32'h0000_000E, 32'h0000_000E, 4, 0};
      vecs[7] = '{8'h80, 4'd8,  4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_01FE, 9, 0};
      vecs[8] = '{8'h0A, 4'd4,  4'd1, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_001E, 5, 2};
      vecs[9] = '{8'h0A, 4'd4,  4'd1, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_001E, 5, 5};

      // reset held across a clock edge
      @(negedge clk);
      chk("reset outs", 16'({out, valid, busy, done}), 16'h0);
      chk("reset LEDR", 16'(LEDR), 16'h0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // asynchronous reset in the middle of a transmission
      @(negedge clk);
      start = 1'b1; pattern = 8'h0A; length = 4'd4; passes = 4'd1; bit_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ar c1 out", 16'(out), 16'd1);
      @(negedge clk);
      chk("ar c2 out/valid", 16'({out, valid}), 16'b01);
      #1 reset = 1'b1;
      #1;
      chk("ar async outs", 16'({out, valid, busy, done}), 16'h0);
      chk("ar async LEDR", 16'(LEDR), 16'h0);
      @(negedge clk);
      chk("ar held outs", 16'({out, valid, busy, done}), 16'h0);
      reset = 1'b0;
      run_vec(10, vecs[0]);

      run_random(3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
